// File: rtl/fifo_downsize_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_downsize_rd_ctrl_if
// Groups the FIFO read-side controls and the narrow output stream of the
// downsizing FIFO read controller.
//
// Signals:
//   fifo_empty      FIFO empty flag (pre-pop in the pop cycle)
//   fifo_data       FIFO output register: selected lane plus metadata
//   fifo_rd_en      pop the head entry
//   fifo_rd_src     lane select into the FIFO
//   fifo_data_hold  freeze the FIFO output register
//   m_valid         narrow beat valid
//   m_ready         downstream ready
//   m_data          narrow beat data
//   m_last          last beat of transfer
//   protocol_err    sticky malformed-entry flag
//
// Modports:
//   master  the read controller
//   slave   the FIFO plus downstream consumer
// -----------------------------------------------------------------------------
interface fifo_downsize_rd_ctrl_if #(
    parameter int DATA_WIDTH_IN    = 64,
    parameter int DATA_WIDTH_OUT   = 32,
    parameter int EXTRA_DATA_WIDTH = 8
);
    localparam int RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int SEL_W = $clog2(RATIO);

    logic                                       fifo_empty;
    logic [DATA_WIDTH_OUT+EXTRA_DATA_WIDTH-1:0] fifo_data;
    logic                                       fifo_rd_en;
    logic [SEL_W-1:0]                           fifo_rd_src;
    logic                                       fifo_data_hold;
    logic                                       m_valid;
    logic                                       m_ready;
    logic [DATA_WIDTH_OUT-1:0]                  m_data;
    logic                                       m_last;
    logic                                       protocol_err;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, fifo_rd_src, fifo_data_hold,
        output m_valid, m_data, m_last, protocol_err
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, fifo_rd_src, fifo_data_hold,
        input  m_valid, m_data, m_last, protocol_err
    );
endinterface

// File: rtl/fifo_downsize_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_downsize_rd_ctrl
// Read-side controller for the downsizing FIFO. Walks the narrow lanes of the
// head entry (from its start lane to its end lane) by steering the FIFO lane
// select / hold / pop controls, and presents them as a narrow valid/ready
// stream with last-beat marking.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   fifo_downsize_rd_ctrl_if.master (FIFO controls + narrow stream)
// -----------------------------------------------------------------------------
module fifo_downsize_rd_ctrl #(
    parameter int DATA_WIDTH_IN    = 64,
    parameter int DATA_WIDTH_OUT   = 32,
    parameter int EXTRA_DATA_WIDTH = 8
) (
    input logic                     clk,
    input logic                     rst,
    fifo_downsize_rd_ctrl_if.master bus
);
    localparam int RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int SEL_W = $clog2(RATIO);

    typedef enum logic [1:0] {StIdle, StPrime, StSend, StDrain} state_t;

    state_t           state;
    logic [SEL_W-1:0] cur;
    logic [SEL_W-1:0] end_r;
    logic             last_r;
    logic             err_r;

    // Metadata fields of the head entry; only meaningful in StPrime.
    logic [SEL_W-1:0] meta_start;
    logic [SEL_W-1:0] meta_end;
    logic             meta_last;
    logic             at_end;

    assign meta_start = bus.fifo_data[DATA_WIDTH_OUT +: SEL_W];
    assign meta_end   = bus.fifo_data[DATA_WIDTH_OUT + SEL_W +: SEL_W];
    assign meta_last  = bus.fifo_data[DATA_WIDTH_OUT + 2*SEL_W];
    assign at_end     = (cur == end_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            cur    <= '0;
            end_r  <= '0;
            last_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (!bus.fifo_empty) state <= StPrime;
                end
                StPrime: begin
                    cur    <= meta_start;
                    last_r <= meta_last;
                    // A reversed range collapses to a single beat of the start lane.
                    if (meta_end < meta_start) begin
                        end_r <= meta_start;
                        err_r <= 1'b1;
                    end else begin
                        end_r <= meta_end;
                    end
                    state <= StSend;
                end
                StSend: begin
                    if (bus.m_ready) begin
                        if (at_end) state <= StDrain;
                        else        cur   <= cur + SEL_W'(1);
                    end
                end
                StDrain: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // FIFO steering: the output register reloads on every edge unless held,
    // so the lane select always names the lane wanted in the next cycle.
    always_comb begin
        bus.fifo_rd_src    = '0;
        bus.fifo_data_hold = 1'b0;
        bus.fifo_rd_en     = 1'b0;
        unique case (state)
            StPrime: bus.fifo_rd_src = meta_start;
            StSend: begin
                if (!bus.m_ready) begin
                    bus.fifo_data_hold = 1'b1;
                    bus.fifo_rd_src    = cur;
                end else if (!at_end) begin
                    bus.fifo_rd_src = cur + SEL_W'(1);
                end else begin
                    bus.fifo_rd_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.m_valid      = (state == StSend);
    assign bus.m_last       = (state == StSend) && last_r && at_end;
    assign bus.m_data       = bus.fifo_data[DATA_WIDTH_OUT-1:0];
    assign bus.protocol_err = err_r;
endmodule
